fpu_result_fifo: RTL and testbench
==================================

FPU_RESULT_FIFO -- requirements
Module: fpu_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered results; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  pipeline output stage holds a result.
REQ-005 SHALL have port in_data  input  float_point_num (32: sign 1, exp 8, mant 23)  result from the last pipeline stage.
REQ-006 SHALL have port pipe_en  output  1  advance enable driven to the producing pipeline's en input.
REQ-007 SHALL have port out_valid  output  1  out_data holds a buffered result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 SHALL have port out_data  output  float_point_num  oldest buffered result.
REQ-010 SHALL have port out_class  output  4  {is_nan, is_inf, is_zero, is_denorm} of out_data.
REQ-011 SHALL have port level  output  $clog2(DEPTH+1)  current number of buffered results.

Function
REQ-012 SHALL implement a first-word-fall-through FIFO of float_point_num entries with circular read and write pointers and an occupancy counter.
REQ-013 SHALL drive pipe_en = 1 when rst = 0 and level < DEPTH, combinationally; otherwise 0.
REQ-014 SHALL push in_data when in_valid = 1 and pipe_en = 1; no other condition causes a push.
REQ-015 SHALL pop when out_valid = 1 and out_ready = 1.
REQ-016 SHALL drive out_valid = 1 exactly when level > 0, combinationally from the registered counter.
REQ-017 SHALL drive out_data from the entry at the read pointer when level > 0, and all-zero when level = 0.
REQ-018 SHALL make a pushed result visible on out_data with out_valid = 1 in the cycle after the push; there is no bypass from in_data.
REQ-019 SHALL, on simultaneous push and pop, keep level unchanged and advance both pointers.
REQ-020 SHALL, when full, drop pipe_en even if a pop occurs in the same cycle; the push resumes one cycle later.
REQ-021 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-022 SHALL ignore out_ready when level = 0, leaving level at 0.
REQ-023 SHALL keep out_data and out_valid stable while out_valid = 1 and out_ready = 0.

Reset
REQ-024 SHALL, while rst = 1, clear both pointers and level to 0 and drive out_valid = 0, out_data = 0, out_class = 0, and pipe_en = 0.
REQ-025 SHALL, on reset asserted mid-operation, discard all buffered results; memory contents need not be cleared.
REQ-026 SHALL drive pipe_en = 1 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with FPU_RESULT_CLASSIFY_EN defined, classify each result at push time and store the 4 class bits alongside it:
- nan: exp = 255 and mant != 0
- inf: exp = 255 and mant = 0
- zero: exp = 0 and mant = 0
- denorm: exp = 0 and mant != 0
REQ-028 SHALL, without FPU_RESULT_CLASSIFY_EN, keep the out_class port, tie it to 0, and add no class storage.

Structure
REQ-029 SHALL take float_point_num and the class bit-index constants (CLS_NAN = 3, CLS_INF = 2, CLS_ZERO = 1, CLS_DENORM = 0) from package float_struct.
REQ-030 SHALL place classification in sub-module fpu_classify (combinational, float_point_num in, 4-bit class out), instantiated only under the macro.

Verification
REQ-031 SHALL cover single result: push {0, 0x7F, 0x000000}, out_ready = 1 -> out_valid = 1 next cycle with out_data = 0x3F800000, then level = 0.
REQ-032 SHALL cover fill with DEPTH = 4 and out_ready = 0: push 4 results -> level = 4, pipe_en = 0; a fifth in_valid is not pushed.
REQ-033 SHALL cover full with simultaneous pop: full, out_ready = 1 and in_valid = 1 -> pipe_en = 0 that cycle, level = 3, push accepted next cycle, level = 4.
REQ-034 SHALL cover wrap-around: stream 10 results with out_ready = 1 -> outputs in order with no loss or duplication.
REQ-035 SHALL cover reset mid-operation: level = 3, pulse rst -> level = 0, out_valid = 0, pipe_en = 0 during rst, pipe_en = 1 after.
REQ-036 SHALL cover classification (macro on): push 0x7FC00000, 0xFF800000, 0x80000000, 0x00000001 -> out_class 1000, 0100, 0010, 0001; macro off -> out_class 0000.

Source files
------------

// File: rtl/float_struct.sv
// Shared floating-point result types: the 32-bit single-precision layout and
// the bit positions of the 4-bit result class vector.
package float_struct;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    localparam int CLS_NAN    = 3;
    localparam int CLS_INF    = 2;
    localparam int CLS_ZERO   = 1;
    localparam int CLS_DENORM = 0;

endpackage

// File: rtl/fpu_classify.sv
// Combinational classifier of a single-precision value into
// {is_nan, is_inf, is_zero, is_denorm}.
module fpu_classify
    import float_struct::*;
(
    input  float_point_num value,
    output logic [3:0]     cls
);

    logic exp_max;
    logic exp_min;
    logic mant_zero;

    always_comb begin
        exp_max   = &value.exp;
        exp_min   = ~|value.exp;
        mant_zero = ~|value.mant;
        cls                 = '0;
        cls[CLS_NAN]    = exp_max & ~mant_zero;
        cls[CLS_INF]    = exp_max &  mant_zero;
        cls[CLS_ZERO]   = exp_min &  mant_zero;
        cls[CLS_DENORM] = exp_min & ~mant_zero;
    end

endmodule

// File: rtl/fpu_result_fifo.sv
// First-word-fall-through buffer behind the FPU pipeline; back-pressures the
// pipeline via pipe_en. Optional result classification: FPU_RESULT_CLASSIFY_EN.
module fpu_result_fifo
    import float_struct::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  float_point_num             in_data,
    output logic                       pipe_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output float_point_num             out_data,
    output logic [3:0]                 out_class,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    float_point_num mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [LW-1:0]  count;
    logic           push;
    logic           pop;

    // Full blocks the pipeline even when a pop frees a slot this cycle.
    assign pipe_en   = !rst && (count < LW'(DEPTH));
    assign out_valid = !rst && (count != '0);
    assign push      = in_valid && pipe_en;
    assign pop       = out_valid && out_ready;
    assign level     = count;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + LW'(1);
            else if (pop && !push) count <= count - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef FPU_RESULT_CLASSIFY_EN
    logic [3:0] cls_mem [DEPTH];
    logic [3:0] in_cls;

    fpu_classify u_classify (
        .value (in_data),
        .cls   (in_cls)
    );

    always_ff @(posedge clk) begin
        if (push) cls_mem[wr_ptr] <= in_cls;
    end

    assign out_class = out_valid ? cls_mem[rd_ptr] : '0;
`else
    assign out_class = '0;
`endif

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Bench for fpu_result_fifo: queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fpu_result_fifo;
    import float_struct::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);

    logic           clk = 0;
    logic           rst;
    logic           in_valid;
    float_point_num in_data;
    logic           pipe_en;
    logic           out_valid;
    logic           out_ready;
    float_point_num out_data;
    logic [3:0]     out_class;
    logic [LW-1:0]  level;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_q [$];
    logic [31:0] dut_pops [$];
    int          model_pops = 0;

    fpu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .pipe_en   (pipe_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_class (out_class),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] class_of(input logic [31:0] v);
        logic [3:0] c;
        int e;
        int m;
        e = int'(v[30:23]);
        m = int'(v[22:0]);
        c = 4'b0000;
`ifdef FPU_RESULT_CLASSIFY_EN
        if (e == 255 && m != 0) c = 4'b1000;
        if (e == 255 && m == 0) c = 4'b0100;
        if (e == 0   && m == 0) c = 4'b0010;
        if (e == 0   && m != 0) c = 4'b0001;
`endif
        return c;
    endfunction

    // Reference model: a plain queue updated with the spec's push/pop rules.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        do_pop  = !rst && model_q.size() > 0 && out_ready;
        do_push = !rst && model_q.size() < DEPTH && in_valid;
        if (rst) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                model_pops++;
            end
            if (do_push) model_q.push_back(in_data);
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [31:0] exp_data;
        bit          exp_valid;
        #2;
        exp_valid = !rst && model_q.size() > 0;
        exp_data  = exp_valid ? model_q[0] : 32'h0;
        check("level",     32'(level),     32'(model_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_data",  out_data,       exp_data);
        check("out_class", 32'(out_class), 32'(class_of(exp_data)));
        check("pipe_en",   32'(pipe_en),   32'(!rst && model_q.size() < DEPTH));
        if (out_valid && out_ready) dut_pops.push_back(out_data);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) v[22:0] = 23'h0;
        return v;
    endfunction

    initial begin
        logic [31:0] stream [10];
        logic [31:0] cls_vals [4];
        logic [3:0]  cls_exp [4];
        int          base;

        rst = 1; in_valid = 0; out_ready = 0; in_data = '0;
        cyc(); cyc(); #1;
        check("rst_level",     32'(level),     0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_pipe_en",   32'(pipe_en),   0);
        check("rst_out_data",  out_data,       0);
        check("rst_out_class", 32'(out_class), 0);

        cyc(); rst = 0; #1;
        check("pipe_en_after_rst", 32'(pipe_en), 1);

        // single result
        in_valid = 1; in_data = {1'b0, 8'h7F, 23'h0}; out_ready = 1;
        cyc(); in_valid = 0; #1;
        check("single_valid", 32'(out_valid), 1);
        check("single_data",  out_data,       32'h3F800000);
        cyc(); #1;
        check("single_level_after", 32'(level), 0);

        // fill to DEPTH with no consumer
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = 32'h4000_0000 + 32'(i);
            cyc();
        end
        in_data = 32'h4100_0000; #1;
        check("fill_level",   32'(level),   4);
        check("fill_pipe_en", 32'(pipe_en), 0);
        cyc(); #1;
        check("fifth_not_pushed", 32'(level), 4);

        // full with simultaneous pop: no push this cycle, push next cycle
        out_ready = 1; in_data = 32'h4200_0000; #1;
        check("full_pop_pipe_en", 32'(pipe_en), 0);
        cyc(); out_ready = 0; #1;
        check("full_pop_level",   32'(level),   3);
        check("full_pop_reopen",  32'(pipe_en), 1);
        cyc(); in_valid = 0; #1;
        check("full_pop_refill", 32'(level), 4);

        out_ready = 1;
        repeat (5) cyc();
        #1 check("drained", 32'(level), 0);

        // wrap-around stream
        base = dut_pops.size();
        for (int i = 0; i < 10; i++) begin
            stream[i] = 32'h4480_0000 + 32'(i * 3);
            in_valid = 1; in_data = stream[i];
            cyc();
        end
        in_valid = 0;
        repeat (3) cyc();
        #3;
        check("stream_count", 32'(dut_pops.size() - base), 10);
        for (int i = 0; i < 10; i++)
            if (base + i < dut_pops.size())
                check("stream_order", dut_pops[base + i], stream[i]);

        // reset mid-operation
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = rand_float();
            cyc();
        end
        in_valid = 0; #1;
        check("pre_rst_level", 32'(level), 3);
        rst = 1; #1;
        check("mid_rst_pipe_en",   32'(pipe_en),   0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        cyc(); #1;
        check("mid_rst_level", 32'(level), 0);
        cyc(); rst = 0; #1;
        check("post_rst_pipe_en", 32'(pipe_en), 1);
        check("post_rst_level",   32'(level),   0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc();
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 2) == 0 || i > 200 && $urandom_range(0, 1) == 0;
            in_data   = rand_float();
        end
        cyc(); rst = 0; in_valid = 0; out_ready = 1;
        repeat (6) cyc();
        out_ready = 0;

        // classification
        cls_vals[0] = 32'h7FC00000; cls_exp[0] = 4'b1000;
        cls_vals[1] = 32'hFF800000; cls_exp[1] = 4'b0100;
        cls_vals[2] = 32'h80000000; cls_exp[2] = 4'b0010;
        cls_vals[3] = 32'h00000001; cls_exp[3] = 4'b0001;
`ifndef FPU_RESULT_CLASSIFY_EN
        for (int i = 0; i < 4; i++) cls_exp[i] = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = cls_vals[i];
            cyc();
        end
        in_valid = 0; out_ready = 1; #1;
        for (int i = 0; i < 4; i++) begin
            check("class_data", out_data, cls_vals[i]);
            check("class_bits", 32'(out_class), 32'(cls_exp[i]));
            cyc(); #1;
        end
        check("class_drained", 32'(level), 0);

        cyc(); #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
